// File: rtl/chien_consts_pkg.sv
// Shared constants for the RS(544,522) Chien search: GF(2^10) field, lane geometry,
// and the constant-multiplier tables α^(-k·t) and α^(-k·P).
package chien_consts_pkg;

  localparam int unsigned W     = 10;
  localparam int unsigned T     = 11;
  localparam int unsigned P     = 32;
  localparam int unsigned N     = 1023;
  localparam int unsigned N_CW  = 544;
  localparam int unsigned POS_W = $clog2(N);
  localparam int unsigned NB    = (N_CW + P - 1) / P;
  localparam int unsigned B_W   = $clog2(NB);

  localparam logic [W:0] FIELD_POLY = 11'h409;

  typedef logic [W-1:0] sym_t;
  typedef logic [P-1:0][T:0][W-1:0] kt_tab_t;
  typedef logic [T:0][W-1:0] kp_tab_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN, ST_DONE} state_t;

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(W); i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[W-2:0], 1'b0} ^ (sh[W-1] ? FIELD_POLY[W-1:0] : W'(0));
    end
    return acc;
  endfunction

  // Square-and-multiply keeps constant elaboration cheap.
  function automatic sym_t alpha_pow(input int unsigned e);
    sym_t res;
    sym_t base;
    int unsigned x;
    res  = W'(1);
    base = W'(2);
    x    = e % N;
    for (int i = 0; i < int'(W); i++) begin
      if (x[i]) res = gf_mul(res, base);
      base = gf_mul(base, base);
    end
    return res;
  endfunction

  function automatic sym_t alpha_neg(input int unsigned e);
    return alpha_pow((N - (e % N)) % N);
  endfunction

  function automatic kt_tab_t build_kt();
    kt_tab_t tab;
    for (int unsigned t = 0; t < P; t++)
      for (int unsigned k = 0; k < T + 1; k++)
        tab[t][k] = alpha_neg(k * t);
    return tab;
  endfunction

  function automatic kp_tab_t build_kp();
    kp_tab_t tab;
    for (int unsigned k = 0; k < T + 1; k++)
      tab[k] = alpha_neg(k * P);
    return tab;
  endfunction

  localparam kt_tab_t ALPHA_NEG_KT = build_kt();
  localparam kp_tab_t ALPHA_NEG_KP = build_kp();

endpackage

// File: rtl/gf1024_mul_pb_k5_flat.sv
// Combinational GF(2^10) polynomial-basis multiplier, reduction by x^10+x^3+1.
module gf1024_mul_pb_k5_flat (
  input  logic [9:0] A,
  input  logic [9:0] B,
  output logic [9:0] P
);

  localparam logic [9:0] RED = 10'h009;

  logic [9:0] acc;
  logic [9:0] sh;

  always_comb begin
    acc = '0;
    sh  = A;
    for (int i = 0; i < 10; i++) begin
      if (B[i]) acc = acc ^ sh;
      sh = {sh[8:0], 1'b0} ^ (sh[9] ? RED : 10'h000);
    end
    P = acc;
  end

endmodule

// File: rtl/rs_chien_search.sv
// Parallel Chien search: evaluates Λ(α^(-i)) for i = 0..543, 32 points per cycle,
// and reports roots as codeword indices (n-1-i).
module rs_chien_search
  import chien_consts_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [W-1:0]     sigma_low_i [0:T],
  input  logic             sigma_valid_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [P-1:0]     hit_mask_o,
  output logic [POS_W-1:0] pos_bus_o [0:P-1]
);

  state_t             state;
  logic [B_W-1:0]     batch;
  sym_t               coef   [0:T];
  sym_t               r      [0:T];
  sym_t               r_next [0:T];
  sym_t               prod   [0:P-1][0:T];
  logic [P-1:0]       hit_c;
  logic [POS_W-1:0]   pos_c  [0:P-1];
  logic               lambda_nz_c;

  // r_k stays nonzero under nonzero constant scaling, so this tracks "any λ_k != 0".
  always_comb begin
    lambda_nz_c = 1'b0;
    for (int k = 0; k < int'(T) + 1; k++) lambda_nz_c = lambda_nz_c | (|r[k]);
  end

  for (genvar k = 0; k < int'(T) + 1; k++) begin : g_upd
    gf1024_mul_pb_k5_flat u_upd (.A(r[k]), .B(ALPHA_NEG_KP[k]), .P(r_next[k]));
  end

  for (genvar t = 0; t < int'(P); t++) begin : g_lane
    sym_t             syn;
    logic [POS_W-1:0] idx;

    for (genvar k = 0; k < int'(T) + 1; k++) begin : g_term
      gf1024_mul_pb_k5_flat u_term (.A(r[k]), .B(ALPHA_NEG_KT[t][k]), .P(prod[t][k]));
    end

    always_comb begin
      syn = '0;
      for (int k = 0; k < int'(T) + 1; k++) syn = syn ^ prod[t][k];
    end

    assign idx      = POS_W'(batch) * POS_W'(P) + POS_W'(t);
    assign hit_c[t] = (syn == '0) && (32'(idx) < N_CW) && lambda_nz_c;
    assign pos_c[t] = hit_c[t] ? (POS_W'(N_CW - 1) - idx) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      batch      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hit_mask_o <= '0;
      for (int k = 0; k < int'(T) + 1; k++) begin
        coef[k] <= '0;
        r[k]    <= '0;
      end
      for (int t = 0; t < int'(P); t++) pos_bus_o[t] <= '0;
    end else begin
      done_o     <= 1'b0;
      hit_mask_o <= '0;
      for (int t = 0; t < int'(P); t++) pos_bus_o[t] <= '0;
      case (state)
        ST_IDLE: begin
          if (sigma_valid_i)
            for (int k = 0; k < int'(T) + 1; k++) coef[k] <= sigma_low_i[k];
          if (start_i) begin
            state  <= ST_LOAD;
            busy_o <= 1'b1;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < int'(T) + 1; k++) r[k] <= coef[k];
          batch <= '0;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          hit_mask_o <= hit_c;
          for (int t = 0; t < int'(P); t++) pos_bus_o[t] <= pos_c[t];
          for (int k = 0; k < int'(T) + 1; k++) r[k] <= r_next[k];
          if (batch == B_W'(NB - 1)) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            batch <= batch + B_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_chien_search.sv
// Self-checking bench for rs_chien_search against a log/antilog-table polynomial evaluator.
module tb_rs_chien_search;

  localparam int NL  = 12;
  localparam int NP  = 32;
  localparam int NCW = 544;
  localparam int NG  = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sigma_low [0:NL-1];
  logic        sigma_valid = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hit_mask;
  logic [9:0]  pos_bus [0:NP-1];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_t [0:NG-1];
  int log_t [0:1023];
  int val   [0:NCW-1];
  int seen  [0:NCW-1];

  rs_chien_search dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sigma_low_i  (sigma_low),
    .sigma_valid_i(sigma_valid),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .hit_mask_o   (hit_mask),
    .pos_bus_o    (pos_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % NG];
  endfunction

  // Λ(α^(-i)) = XOR_k λ_k · α^(-i·k)
  function automatic int eval_lam(input int lam [0:NL-1], input int i);
    int acc;
    acc = 0;
    for (int k = 0; k < NL; k++)
      acc = acc ^ gmul(lam[k], exp_t[(NG - (i * k) % NG) % NG]);
    return acc;
  endfunction

  task automatic drive_lam(input int lam [0:NL-1]);
    for (int k = 0; k < NL; k++) sigma_low[k] = 10'(lam[k]);
  endtask

  task automatic run_sweep(input int lam [0:NL-1], input bit preload, input int reset_cyc);
    bit          nz;
    bit          after_rst;
    logic [31:0] ehit;
    int          epos;
    int          ii;
    nz = 1'b0;
    for (int k = 0; k < NL; k++) if (lam[k] != 0) nz = 1'b1;
    for (int i = 0; i < NCW; i++) begin
      val[i]  = eval_lam(lam, i);
      seen[i] = 0;
    end
    if (preload) begin
      @(negedge clk);
      drive_lam(lam);
      sigma_valid = 1'b1;
      start = 1'b0;
    end
    @(negedge clk);
    check_eq("c0 busy", 32'(busy), 32'd0);
    check_eq("c0 done", 32'(done), 32'd0);
    check_eq("c0 hit", hit_mask, 32'd0);
    if (preload) begin
      for (int k = 0; k < NL; k++) sigma_low[k] = 10'($urandom);
      sigma_valid = 1'b0;
    end else begin
      drive_lam(lam);
      sigma_valid = 1'b1;
    end
    start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      after_rst = (reset_cyc > 0) && (c > reset_cyc);
      ehit = '0;
      check_eq($sformatf("c%0d busy", c), 32'(busy), (!after_rst && c <= 18) ? 32'd1 : 32'd0);
      check_eq($sformatf("c%0d done", c), 32'(done), (!after_rst && c == 19) ? 32'd1 : 32'd0);
      for (int t = 0; t < NP; t++) begin
        epos = 0;
        if (!after_rst && c >= 3) begin
          ii = (c - 3) * NP + t;
          if (ii < NCW && nz && val[ii] == 0) begin
            ehit[t] = 1'b1;
            epos = NCW - 1 - ii;
          end
        end
        check_eq($sformatf("c%0d pos%0d", c, t), 32'(pos_bus[t]), 32'(epos));
        if (hit_mask[t] && int'(pos_bus[t]) < NCW) seen[pos_bus[t]]++;
      end
      check_eq($sformatf("c%0d hit", c), hit_mask, ehit);
      start = 1'b0;
      sigma_valid = 1'b0;
      rst = 1'b0;
      if (c == 6) begin
        start = 1'b1;
        sigma_valid = 1'b1;
        for (int k = 0; k < NL; k++) sigma_low[k] = 10'($urandom);
      end
      if (c == reset_cyc) rst = 1'b1;
    end
  endtask

  function automatic int seen_total();
    int s;
    s = 0;
    for (int i = 0; i < NCW; i++) s += seen[i];
    return s;
  endfunction

  initial begin
    int lam [0:NL-1];
    int v;
    int nroots;
    int roots [0:10];
    bit taken [0:NCW-1];
    int pick;
    int a;

    v = 1;
    for (int j = 0; j < NG; j++) begin
      exp_t[j] = v;
      log_t[v] = j;
      v = v << 1;
      if ((v & 32'h400) != 0) v = v ^ 32'h409;
    end
    for (int k = 0; k < NL; k++) sigma_low[k] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst hit", hit_mask, 32'd0);
    check_eq("rst pos0", 32'(pos_bus[0]), 32'd0);
    check_eq("rst pos31", 32'(pos_bus[31]), 32'd0);
    rst = 1'b0;

    lam = '{default: 0};
    lam[0] = 1; lam[1] = 3; lam[2] = 2;
    run_sweep(lam, 1'b0, 0);
    check_eq("t1 pos543", 32'(seen[543]), 32'd1);
    check_eq("t1 pos542", 32'(seen[542]), 32'd1);
    check_eq("t1 total", 32'(seen_total()), 32'd2);

    lam = '{default: 0};
    lam[0] = 1; lam[1] = 32'h136;
    run_sweep(lam, 1'b0, 0);
    check_eq("t2 pos511", 32'(seen[511]), 32'd1);
    check_eq("t2 total", 32'(seen_total()), 32'd1);

    lam = '{default: 0};
    lam[0] = 1; lam[1] = exp_t[543];
    run_sweep(lam, 1'b1, 0);
    check_eq("t3 pos0", 32'(seen[0]), 32'd1);
    check_eq("t3 total", 32'(seen_total()), 32'd1);

    lam = '{default: 0};
    lam[0] = 1;
    run_sweep(lam, 1'b0, 0);
    check_eq("t4 total", 32'(seen_total()), 32'd0);

    lam = '{default: 0};
    run_sweep(lam, 1'b0, 0);
    check_eq("t5 total", 32'(seen_total()), 32'd0);

    lam = '{default: 0};
    lam[0] = 1; lam[1] = 3; lam[2] = 2;
    run_sweep(lam, 1'b0, 10);
    check_eq("t6 total", 32'(seen_total()), 32'd2);
    run_sweep(lam, 1'b0, 0);
    check_eq("t6 fresh total", 32'(seen_total()), 32'd2);

    for (int it = 0; it < 10; it++) begin
      nroots = $urandom_range(1, 11);
      for (int i = 0; i < NCW; i++) taken[i] = 1'b0;
      lam = '{default: 0};
      lam[0] = $urandom_range(1, 1023);
      for (int r = 0; r < nroots; r++) begin
        pick = $urandom_range(0, NCW - 1);
        while (taken[pick]) pick = $urandom_range(0, NCW - 1);
        taken[pick] = 1'b1;
        roots[r] = pick;
        a = exp_t[pick];
        for (int k = NL - 1; k > 0; k--) lam[k] = lam[k] ^ gmul(a, lam[k - 1]);
      end
      run_sweep(lam, it[0], 0);
      check_eq($sformatf("rnd%0d total", it), 32'(seen_total()), 32'(nroots));
      for (int r = 0; r < nroots; r++)
        check_eq($sformatf("rnd%0d root%0d", it, roots[r]), 32'(seen[NCW - 1 - roots[r]]), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_chien_search.md
# rs_chien_search

Parallel Chien search for the RS(544,522) decoder over GF(2^10). It sits after the key-equation solver (RiBM) and before error-value evaluation and correction. It takes the low-order-first error-locator polynomial Λ(x), evaluates it at x = α^(−i) for i = 0…543, 32 points per clock, and reports roots as codeword array indices (n−1−i). A full sweep takes 17 scan cycles.

## Interface
Parameters:
- W, 10: symbol width (GF(2^10)).
- T, 11: locator max degree; Λ has T+1 coefficients.
- P, 32: evaluation lanes per cycle.
- N, 1023: multiplicative group order.
- n, 544: codeword length.

Ports:
- clk_i, in, 1: clock. One clock domain.
- rst_i, in, 1: reset, synchronous and active-high.
- sigma_low_i[0:T], in, W each: Λ coefficients; index k holds λ_k (λ_0 first).
- sigma_valid_i, in, 1: coefficients on sigma_low_i are valid.
- start_i, in, 1: launch one sweep.
- busy_o, out, 1: LOAD/SCAN in progress.
- done_o, out, 1: one-cycle pulse at the end of the sweep.
- hit_mask_o, out, P: lane t found a root this cycle.
- pos_bus_o[0:P−1], out, $clog2(N)=10 each: codeword index for lane t.

## Operation
- Field: polynomial basis, primitive polynomial x^10+x^3+1 (0x409), α = 0x002.
- sigma_valid_i in IDLE latches sigma_low_i into the coefficient registers.
- start_i in IDLE launches a sweep. If sigma_valid_i is high in the same cycle, the incoming coefficients are used.
- start_i and sigma_valid_i are ignored outside IDLE.
- FSM states and transitions:
  - IDLE → LOAD on start.
  - LOAD: r_k ← λ_k for k = 0…T; batch counter b ← 0.
  - SCAN: 17 cycles, b = 0…16. Then → DONE.
  - DONE: 1 cycle. Then → IDLE.
- Per SCAN cycle, lane t evaluates i = b·P + t:
  - S_t = XOR over k of r_k · α^(−k·t), using constant multipliers.
  - Then r_k ← r_k · α^(−k·P).
- Hit rule: lane t hits iff S_t = 0, i < n, and at least one λ_k is nonzero. An all-zero Λ reports no hits.
- On a hit, pos_bus_o[t] = (n−1) − i. Lanes without a hit drive hit_mask_o[t] = 0 and pos_bus_o[t] = 0.
- Every i in 0…543 is evaluated exactly once per sweep, so each root is reported exactly once.
- Exponents reduce mod N. For example, α^(−i) = α^((N − i mod N) mod N).

## Timing
- Cycle 0 is the start-accept cycle.
- busy_o is registered: high in cycles 1 (LOAD) through 18 (last SCAN), low otherwise.
- hit_mask_o and pos_bus_o are registered. Batch b is presented in cycle 3+b (cycles 3…19); all other cycles drive zero.
- done_o pulses high for exactly one cycle, in cycle 19, coincident with the batch-16 results.
- Results from batch b never appear before the cycle after batch b's evaluation.
- The next start is accepted from cycle 20 onward.
- Reset values: busy_o = 0, done_o = 0, hit_mask_o = 0, all pos_bus_o = 0; FSM in IDLE; coefficient registers cleared.
- rst_i asserted mid-sweep: the next cycle is IDLE with all outputs at reset values, and no done_o pulse is produced.

## Structure
- Shared package chien_consts_pkg holds:
  - P, T, W.
  - Field polynomial.
  - Constant tables ALPHA_NEG_KT[t][k] = α^(−k·t) and ALPHA_NEG_KP[k] = α^(−k·P), computed by a constant function.
- Sub-module gf1024_mul_pb_k5_flat: purely combinational general GF(2^10) multiplier, ports A[9:0], B[9:0] → P[9:0], using reduction by x^10+x^3+1. Used for register updates and the verification reference; constant multiplies may instantiate it with constant operands so synthesis folds them.
- Lane evaluation lives in a generate loop over P and T.

## Test plan
- Λ = {1, 0x003, 0x002, 0…} (roots i = 0, 1) → hits lane 0 (pos 543) and lane 1 (pos 542) in cycle 3; no other hits; done_o pulses in cycle 19.
- Λ = {1, 0x136, 0…} (α^32; root at i = 32) → only lane 0 hits, pos 511, in cycle 4.
- Λ = {1, α^543, 0…} (root at i = 543) → lane 31 hits, pos 0, in cycle 19 together with done_o.
- Λ = {1, 0…} and Λ all zero → no hits across the sweep; busy_o high cycles 1–18; done_o in cycle 19.
- start_i re-asserted during SCAN, and rst_i asserted in cycle 10 → the re-start is ignored; after reset all outputs are 0; a fresh start yields the correct full result.
- Randomized Λ with 1–11 roots → hit set matches a software evaluation of Λ(α^(−i)) over i = 0…543, with no duplicate indices.
